// File: rtl/prbs_checker_if.sv
// prbs_checker_if: serial PRBS stream and checker status bundle.
//   din        serial PRBS bit (generator Q[0])
//   din_valid  din is meaningful this cycle
//   clr_count  synchronous clear of err_count and bit_count
//   locked     checker is in LOCKED
//   err_pulse  one-cycle pulse per mismatch seen while locked
//   err_count  saturating mismatch count
//   bit_count  saturating count of bits compared while locked
// The master modport is the stream source / status reader; slave is the checker.
interface prbs_checker_if;
  logic        din;
  logic        din_valid;
  logic        clr_count;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [31:0] bit_count;

  modport master (
    output din,
    output din_valid,
    output clr_count,
    input  locked,
    input  err_pulse,
    input  err_count,
    input  bit_count
  );

  modport slave (
    input  din,
    input  din_valid,
    input  clr_count,
    output locked,
    output err_pulse,
    output err_count,
    output bit_count
  );
endinterface

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising serial PRBS checker for a Fibonacci LFSR stream.
// A local replica register is filled from the incoming bits (HUNT), its predictions
// are verified for LOCK_COUNT bits (VERIFY), then it free-runs as a flywheel (LOCKED)
// while mismatches are counted. Too many consecutive mismatches drop back to HUNT.
// Ports:
//   CLK      rising-edge clock
//   n_RESET  synchronous active-low reset
//   bus      prbs_checker_if.slave (din/din_valid/clr_count in, status out)
module prbs_checker #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] TAP_MASK    = 16'h002D,
  parameter int unsigned      LOCK_COUNT  = 32,
  parameter int unsigned      LOSS_THRESH = 4
) (
  input logic            CLK,
  input logic            n_RESET,
  prbs_checker_if.slave  bus
);

  localparam int unsigned FillW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [7:0]         match_q, match_d;
  logic [3:0]         miss_q, miss_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic [15:0]        err_count_q, err_count_d;
  logic [31:0]        bit_count_q, bit_count_d;

  logic pred;
  logic mismatch;
  logic compare_locked;

  // Replica prediction of the next incoming bit.
  assign pred           = ^(s_q & TAP_MASK);
  assign mismatch       = bus.din ^ pred;
  assign compare_locked = bus.din_valid && (state_q == StLocked);

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (!n_RESET) begin
      state_q     <= StHunt;
      s_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
    end
  end

  // Next-state and replica update; nothing moves on idle cycles.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    if (bus.din_valid) begin
      unique case (state_q)
        StHunt: begin
          s_d = {bus.din, s_q[WIDTH-1:1]};
          if (fill_q == FillW'(WIDTH - 1)) begin
            fill_d = '0;
            // An all-zero replica would predict zeros forever; refill instead.
            if (s_d != '0) begin
              state_d = StVerify;
              match_d = '0;
            end
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        StVerify: begin
          s_d = {bus.din, s_q[WIDTH-1:1]};
          if (mismatch) begin
            state_d = StHunt;
            fill_d  = '0;
          end else if (match_q == 8'(LOCK_COUNT - 1)) begin
            state_d = StLocked;
            miss_d  = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
        StLocked: begin
          // Flywheel: the replica runs on its own prediction, never on din.
          s_d = {pred, s_q[WIDTH-1:1]};
          if (mismatch) begin
            if (miss_q == 4'(LOSS_THRESH - 1)) begin
              state_d = StHunt;
              fill_d  = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // Registered status and counters.
  always_comb begin
    locked_d    = (state_d == StLocked);
    err_pulse_d = compare_locked && mismatch;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;
    if (compare_locked) begin
      if (bit_count_q != '1) bit_count_d = bit_count_q + 1'b1;
      if (mismatch && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
    end
    // Clear beats a coincident compare.
    if (bus.clr_count) begin
      err_count_d = '0;
      bit_count_d = '0;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;

  logic        CLK;
  logic        n_RESET;
  logic [15:0] gen;
  int          passed;
  int          total;

  prbs_checker_if bus ();

  prbs_checker #(
    .WIDTH      (16),
    .TAP_MASK   (16'h002D),
    .LOCK_COUNT (32),
    .LOSS_THRESH(4)
  ) dut (
    .CLK    (CLK),
    .n_RESET(n_RESET),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One clock: inputs driven here, outputs sampled 1 time unit after the edge.
  task automatic tick(input logic v, input logic d, input logic clr);
    bus.din_valid = v;
    bus.din       = d;
    bus.clr_count = clr;
    @(posedge CLK);
    #1;
  endtask

  // Send the reference generator's Q[0] (optionally inverted), then step it.
  task automatic gen_bit(input logic flip, input logic clr);
    tick(1'b1, gen[0] ^ flip, clr);
    gen = {^(gen & 16'h002D), gen[15:1]};
  endtask

  task automatic idle();
    tick(1'b0, 1'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    n_RESET = 1'b0;
    tick(1'b1, 1'($urandom), 1'b1);
    n_RESET = 1'b1;
    gen = 16'hFFFF;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.locked !== 1'b0) $display("FAIL reset_locked got %0b want 0", bus.locked);
    else passed++;
    total++;
    if (bus.err_pulse !== 1'b0) $display("FAIL reset_err_pulse got %0b want 0", bus.err_pulse);
    else passed++;
    total++;
    if (bus.err_count !== 16'd0) $display("FAIL reset_err_count got %0d want 0", bus.err_count);
    else passed++;
    total++;
    if (bus.bit_count !== 32'd0) $display("FAIL reset_bit_count got %0d want 0", bus.bit_count);
    else passed++;
  endtask

  task automatic test_lock();
    do_reset();
    repeat (47) gen_bit(1'b0, 1'b0);
    total++;
    if (bus.locked !== 1'b0) $display("FAIL lock_early got %0b want 0", bus.locked);
    else passed++;
    gen_bit(1'b0, 1'b0);
    total++;
    if (bus.locked !== 1'b1) $display("FAIL lock_48 got %0b want 1", bus.locked);
    else passed++;
    total++;
    if (bus.err_count !== 16'd0) $display("FAIL lock_err_count got %0d want 0", bus.err_count);
    else passed++;
    total++;
    if (bus.bit_count !== 32'd0) $display("FAIL lock_bit_count got %0d want 0", bus.bit_count);
    else passed++;
  endtask

  task automatic test_single_error();
    gen_bit(1'b1, 1'b0);
    total++;
    if (bus.err_pulse !== 1'b1) $display("FAIL single_pulse got %0b want 1", bus.err_pulse);
    else passed++;
    total++;
    if (bus.err_count !== 16'd1) $display("FAIL single_err got %0d want 1", bus.err_count);
    else passed++;
    total++;
    if (bus.locked !== 1'b1) $display("FAIL single_locked got %0b want 1", bus.locked);
    else passed++;
    gen_bit(1'b0, 1'b0);
    total++;
    if (bus.err_pulse !== 1'b0) $display("FAIL single_pulse_drop got %0b want 0", bus.err_pulse);
    else passed++;
    repeat (99) gen_bit(1'b0, 1'b0);
    total++;
    if (bus.bit_count !== 32'd101) $display("FAIL single_bits got %0d want 101", bus.bit_count);
    else passed++;
    total++;
    if (bus.err_count !== 16'd1) $display("FAIL single_err_hold got %0d want 1", bus.err_count);
    else passed++;
  endtask

  task automatic test_loss_relock();
    tick(1'b0, 1'b0, 1'b1);
    total++;
    if (bus.bit_count !== 32'd0) $display("FAIL clr_idle_bits got %0d want 0", bus.bit_count);
    else passed++;
    repeat (3) gen_bit(1'b1, 1'b0);
    total++;
    if (bus.locked !== 1'b1) $display("FAIL loss_3_locked got %0b want 1", bus.locked);
    else passed++;
    gen_bit(1'b1, 1'b0);
    total++;
    if (bus.locked !== 1'b0) $display("FAIL loss_4_locked got %0b want 0", bus.locked);
    else passed++;
    total++;
    if (bus.err_count !== 16'd4) $display("FAIL loss_err got %0d want 4", bus.err_count);
    else passed++;
    total++;
    if (bus.err_pulse !== 1'b1) $display("FAIL loss_pulse got %0b want 1", bus.err_pulse);
    else passed++;
    total++;
    if (bus.bit_count !== 32'd4) $display("FAIL loss_bits got %0d want 4", bus.bit_count);
    else passed++;
    repeat (47) gen_bit(1'b0, 1'b0);
    total++;
    if (bus.locked !== 1'b0) $display("FAIL relock_early got %0b want 0", bus.locked);
    else passed++;
    total++;
    if (bus.bit_count !== 32'd4) $display("FAIL hunt_bits got %0d want 4", bus.bit_count);
    else passed++;
    gen_bit(1'b0, 1'b0);
    total++;
    if (bus.locked !== 1'b1) $display("FAIL relock got %0b want 1", bus.locked);
    else passed++;
  endtask

  task automatic test_zero_lockup();
    do_reset();
    repeat (16) tick(1'b1, 1'b0, 1'b0);
    total++;
    if (bus.locked !== 1'b0) $display("FAIL zero_locked got %0b want 0", bus.locked);
    else passed++;
    // Still hunting with an empty fill, so a clean stream locks in exactly 48 bits.
    repeat (47) gen_bit(1'b0, 1'b0);
    total++;
    if (bus.locked !== 1'b0) $display("FAIL zero_early got %0b want 0", bus.locked);
    else passed++;
    gen_bit(1'b0, 1'b0);
    total++;
    if (bus.locked !== 1'b1) $display("FAIL zero_relock got %0b want 1", bus.locked);
    else passed++;
  endtask

  task automatic test_valid_toggle();
    logic seen_pulse;
    seen_pulse = 1'b0;
    do_reset();
    for (int i = 0; i < 47; i++) begin
      gen_bit(1'b0, 1'b0);
      idle();
      seen_pulse |= bus.err_pulse;
    end
    total++;
    if (bus.locked !== 1'b0) $display("FAIL toggle_early got %0b want 0", bus.locked);
    else passed++;
    total++;
    if (seen_pulse !== 1'b0) $display("FAIL toggle_pulse got %0b want 0", seen_pulse);
    else passed++;
    gen_bit(1'b0, 1'b0);
    total++;
    if (bus.locked !== 1'b1) $display("FAIL toggle_lock got %0b want 1", bus.locked);
    else passed++;
    idle();
    total++;
    if (bus.locked !== 1'b1) $display("FAIL toggle_idle_lock got %0b want 1", bus.locked);
    else passed++;
    gen_bit(1'b0, 1'b0);
    idle();
    idle();
    gen_bit(1'b0, 1'b0);
    idle();
    total++;
    if (bus.bit_count !== 32'd2) $display("FAIL toggle_bits got %0d want 2", bus.bit_count);
    else passed++;
    total++;
    if (bus.err_count !== 16'd0) $display("FAIL toggle_err got %0d want 0", bus.err_count);
    else passed++;
  endtask

  task automatic test_clr_on_error();
    repeat (3) gen_bit(1'b0, 1'b0);
    total++;
    if (bus.bit_count !== 32'd5) $display("FAIL clr_pre_bits got %0d want 5", bus.bit_count);
    else passed++;
    gen_bit(1'b1, 1'b1);
    total++;
    if (bus.err_count !== 16'd0) $display("FAIL clr_err got %0d want 0", bus.err_count);
    else passed++;
    total++;
    if (bus.bit_count !== 32'd0) $display("FAIL clr_bits got %0d want 0", bus.bit_count);
    else passed++;
    total++;
    if (bus.err_pulse !== 1'b1) $display("FAIL clr_pulse got %0b want 1", bus.err_pulse);
    else passed++;
    gen_bit(1'b0, 1'b0);
    total++;
    if (bus.bit_count !== 32'd1) $display("FAIL clr_next_bits got %0d want 1", bus.bit_count);
    else passed++;
  endtask

  task automatic test_reset_mid_lock();
    gen_bit(1'b1, 1'b0);
    total++;
    if (bus.err_count !== 16'd1) $display("FAIL mid_pre_err got %0d want 1", bus.err_count);
    else passed++;
    n_RESET = 1'b0;
    tick(1'b1, ~gen[0], 1'b0);
    n_RESET = 1'b1;
    gen = 16'hFFFF;
    total++;
    if (bus.locked !== 1'b0) $display("FAIL mid_locked got %0b want 0", bus.locked);
    else passed++;
    total++;
    if (bus.err_count !== 16'd0) $display("FAIL mid_err got %0d want 0", bus.err_count);
    else passed++;
    total++;
    if (bus.bit_count !== 32'd0) $display("FAIL mid_bits got %0d want 0", bus.bit_count);
    else passed++;
    total++;
    if (bus.err_pulse !== 1'b0) $display("FAIL mid_pulse got %0b want 0", bus.err_pulse);
    else passed++;
    repeat (47) gen_bit(1'b0, 1'b0);
    total++;
    if (bus.locked !== 1'b0) $display("FAIL mid_relock_early got %0b want 0", bus.locked);
    else passed++;
    gen_bit(1'b0, 1'b0);
    total++;
    if (bus.locked !== 1'b1) $display("FAIL mid_relock got %0b want 1", bus.locked);
    else passed++;
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    n_RESET       = 1'b0;
    gen           = 16'hFFFF;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.clr_count = 1'b0;
    test_reset();
    test_lock();
    test_single_error();
    test_loss_relock();
    test_zero_lockup();
    test_valid_toggle();
    test_clr_on_error();
    test_reset_mid_lock();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Serial PRBS checker that sits directly downstream of the team's 16-bit Fibonacci LFSR generator.
- Consumes one generator output bit per valid cycle (generator Q[0]).
- Self-synchronises a local replica LFSR to the incoming stream, declares lock, then counts bit errors.
- Used for link/BIST checking of the pseudo-random stream.

Parameters:
- WIDTH, 16: replica register width; must match the generator length.
- TAP_MASK, 16'h002D: feedback tap mask (bits 0,2,3,5); predicted bit = XOR-reduce(S & TAP_MASK).
- LOCK_COUNT, 32: consecutive matching bits in VERIFY required to declare lock (1..255).
- LOSS_THRESH, 4: consecutive mismatches in LOCKED that force loss of lock (1..15).

Ports:
- CLK  input  1  single clock, rising-edge.
- n_RESET  input  1  reset; synchronous and active-low.
- din  input  1  serial PRBS bit (generator Q[0]).
- din_valid  input  1  din is sampled on a rising edge only when high.
- clr_count  input  1  synchronous clear of err_count and bit_count.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse per mismatch detected in LOCKED.
- err_count  output  16  saturating mismatch count while locked.
- bit_count  output  32  saturating count of bits compared while locked.

Behaviour:
- Reset:
  - On a CLK edge with n_RESET=0: state=HUNT; S=0; fill/match/miss counters=0; locked=0; err_pulse=0; err_count=0; bit_count=0.
  - Reset mid-operation discards lock and replica state.
- Replica register S is updated only on valid bits; shift is S <= {newbit, S[WIDTH-1:1]}.
  - Once filled, S equals the generator state, so P = XOR-reduce(S & TAP_MASK) is the prediction for the next din.
- Cycles with din_valid=0: no state, register or counter change; err_pulse=0.
- HUNT:
  - Each valid bit: newbit=din; fill counter +1.
  - On the WIDTH-th bit: if the resulting S is all-zero (lock-up state), clear the fill counter and stay in HUNT; otherwise go to VERIFY with match=0.
- VERIFY:
  - Each valid bit: newbit=din; compare din with P.
  - Match: match+1; on reaching LOCK_COUNT go to LOCKED.
  - Mismatch: go to HUNT, fill=0. That bit is not counted as fill.
- LOCKED (flywheel):
  - Each valid bit: newbit=P (din is never loaded); bit_count+1 (saturates at 32'hFFFFFFFF).
  - Mismatch: err_pulse=1 on the next cycle; err_count+1 (saturates at 16'hFFFF); miss+1.
  - Match: miss=0.
  - When miss reaches LOSS_THRESH go to HUNT with fill=0. The mismatch that triggers the transition is still counted.
- locked and err_pulse are registered: they reflect the state / compare result of the previous edge.
  - Minimum latency from reset to locked=1 is WIDTH+LOCK_COUNT valid bits; locked rises the cycle after the 48th valid bit's edge at defaults.
- clr_count:
  - Clears err_count and bit_count on the edge; it does not affect state or lock.
  - If clr_count coincides with a compared bit, clear wins: both counters read 0 after the edge and that bit is not counted. err_pulse still fires.
- Counters are not cleared on lock entry or loss; only reset and clr_count clear them.

Test Plan:
- Generator reset to 16'hFFFF, din_valid=1 every cycle -> first 16 bits all 1, bit 17 = 0; locked=1 the cycle after the 48th bit; err_count=0, bit_count=0 at that point.
- Locked, then invert 1 din bit -> single err_pulse cycle; err_count=1; locked stays 1; next 100 clean bits give bit_count=101 (the errored bit plus the 100 clean bits), err_count=1.
- Locked, invert 4 consecutive bits -> err_count=4, locked falls the cycle after the 4th error; relock after a further 48 clean bits.
- din held at 0 for 16 valid bits -> S all-zero, stays in HUNT; no transition to VERIFY, locked=0.
- din_valid toggled 1/0 alternately -> lock after 48 valid bits (96 cycles); idle cycles change nothing.
- clr_count asserted on the same edge as an errored bit while locked -> err_count=0, bit_count=0, err_pulse=1; n_RESET low mid-LOCKED -> locked=0 the next cycle, all counters 0.
